window_buffer_5x5: RTL and testbench



---
 rtl/cnn_pkg.sv | 9 +
 rtl/line_delay.sv | 21 ++
 rtl/window_buffer_5x5.sv | 110 +++++++++++
 tb/tb_window_buffer_5x5.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// cnn_pkg: shared image geometry, FSM states and pixel type for the CNN front end
package cnn_pkg;
    localparam int DATA_W = 8;
    localparam int IMG_W  = 28;
    localparam int IMG_H  = 28;
    localparam int K      = 5;
    typedef enum logic [1:0] {IDLE, RUN, DONE} win_state_t;
    typedef logic signed [DATA_W-1:0] pixel_t;
endpackage

// File: rtl/line_delay.sv
// line_delay: enable-gated IMG_W-deep shift register; output is the pixel IMG_W accepts older
module line_delay
    import cnn_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_i,
    input  logic signed [DATA_W-1:0] d_i,
    output logic signed [DATA_W-1:0] q_o
);
    pixel_t mem_q [IMG_W];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < IMG_W; i++) mem_q[i] <= '0;
        end else if (en_i) begin
            mem_q[0] <= d_i;
            for (int i = 1; i < IMG_W; i++) mem_q[i] <= mem_q[i-1];
        end
    end
    assign q_o = mem_q[IMG_W-1];
endmodule

// File: rtl/window_buffer_5x5.sv
// window_buffer_5x5: streaming 5x5 window generator over a row-major image,
// four chained line delays feed a 5x5 register window exposed as 25 taps
module window_buffer_5x5
    import cnn_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     pixel_valid,
    input  logic signed [DATA_W-1:0] pixel_in,
    output logic                     pixel_ready,
    output logic signed [DATA_W-1:0] data_out_0,  data_out_1,  data_out_2,  data_out_3,  data_out_4,
    output logic signed [DATA_W-1:0] data_out_5,  data_out_6,  data_out_7,  data_out_8,  data_out_9,
    output logic signed [DATA_W-1:0] data_out_10, data_out_11, data_out_12, data_out_13, data_out_14,
    output logic signed [DATA_W-1:0] data_out_15, data_out_16, data_out_17, data_out_18, data_out_19,
    output logic signed [DATA_W-1:0] data_out_20, data_out_21, data_out_22, data_out_23, data_out_24,
    output logic                     valid_out_buf,
    output logic                     frame_done,
    output logic                     busy
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W-1);
    localparam logic [CW-1:0] COL_MIN  = CW'(K-1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H-1);
    localparam logic [RW-1:0] ROW_MIN  = RW'(K-1);

    win_state_t state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic valid_q, valid_d, accept;
    pixel_t row_s [K];
    pixel_t win_q [K][K];

    // row_s[0] is the live pixel, row_s[g+1] the same column g+1 rows earlier
    assign row_s[0] = pixel_in;
    for (genvar g = 0; g < K-1; g++) begin : g_ld
        line_delay u_ld (
            .clk  (clk),
            .rst_n(rst_n),
            .en_i (accept),
            .d_i  (row_s[g]),
            .q_o  (row_s[g+1])
        );
    end

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        pixel_ready = state_q == RUN;
        frame_done  = state_q == DONE;
        busy        = state_q != IDLE;
        accept      = pixel_ready && pixel_valid;
        valid_d     = accept && row_q >= ROW_MIN && col_q >= COL_MIN;
        unique case (state_q)
            IDLE: if (start) begin
                state_d = RUN;
                col_d   = '0;
                row_d   = '0;
            end
            RUN: if (accept) begin
                col_d = col_q == COL_LAST ? '0 : col_q + CW'(1);
                row_d = col_q == COL_LAST ? row_q + RW'(1) : row_q;
                if (row_q == ROW_LAST && col_q == COL_LAST) state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            valid_q <= valid_d;
        end
    end

    // window row i (0 = oldest) takes its newest column from stream K-1-i
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < K; i++)
                for (int j = 0; j < K; j++) win_q[i][j] <= '0;
        end else if (accept) begin
            for (int i = 0; i < K; i++) begin
                for (int j = 0; j < K-1; j++) win_q[i][j] <= win_q[i][j+1];
                win_q[i][K-1] <= row_s[K-1-i];
            end
        end
    end

    assign valid_out_buf = valid_q;
    assign data_out_0  = win_q[0][0]; assign data_out_1  = win_q[0][1]; assign data_out_2  = win_q[0][2];
    assign data_out_3  = win_q[0][3]; assign data_out_4  = win_q[0][4];
    assign data_out_5  = win_q[1][0]; assign data_out_6  = win_q[1][1]; assign data_out_7  = win_q[1][2];
    assign data_out_8  = win_q[1][3]; assign data_out_9  = win_q[1][4];
    assign data_out_10 = win_q[2][0]; assign data_out_11 = win_q[2][1]; assign data_out_12 = win_q[2][2];
    assign data_out_13 = win_q[2][3]; assign data_out_14 = win_q[2][4];
    assign data_out_15 = win_q[3][0]; assign data_out_16 = win_q[3][1]; assign data_out_17 = win_q[3][2];
    assign data_out_18 = win_q[3][3]; assign data_out_19 = win_q[3][4];
    assign data_out_20 = win_q[4][0]; assign data_out_21 = win_q[4][1]; assign data_out_22 = win_q[4][2];
    assign data_out_23 = win_q[4][3]; assign data_out_24 = win_q[4][4];
endmodule

// File: tb/tb_window_buffer_5x5.sv
// tb_window_buffer_5x5: randomized frames checked against an accept-stream model of the window
module tb_window_buffer_5x5;
    localparam int W = 28;
    localparam int H = 28;
    localparam int N = W * H;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, pixel_valid = 1'b0;
    logic signed [7:0] pixel_in = '0;
    logic pixel_ready, valid_out_buf, frame_done, busy;
    logic signed [7:0] taps [25];

    int n_checks = 0, n_fail = 0;
    logic signed [7:0] img [N];
    logic signed [7:0] stream [4096];
    int total = 0;
    logic signed [7:0] first_win [25], last_win [25], wrap_win [25];
    int strobes, first_acc, done_cnt, done_acc;

    always #5 clk = ~clk;

    window_buffer_5x5 dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pixel_valid(pixel_valid), .pixel_in(pixel_in),
        .pixel_ready(pixel_ready),
        .data_out_0(taps[0]),   .data_out_1(taps[1]),   .data_out_2(taps[2]),   .data_out_3(taps[3]),   .data_out_4(taps[4]),
        .data_out_5(taps[5]),   .data_out_6(taps[6]),   .data_out_7(taps[7]),   .data_out_8(taps[8]),   .data_out_9(taps[9]),
        .data_out_10(taps[10]), .data_out_11(taps[11]), .data_out_12(taps[12]), .data_out_13(taps[13]), .data_out_14(taps[14]),
        .data_out_15(taps[15]), .data_out_16(taps[16]), .data_out_17(taps[17]), .data_out_18(taps[18]), .data_out_19(taps[19]),
        .data_out_20(taps[20]), .data_out_21(taps[21]), .data_out_22(taps[22]), .data_out_23(taps[23]), .data_out_24(taps[24]),
        .valid_out_buf(valid_out_buf), .frame_done(frame_done), .busy(busy)
    );

    // tap (i,j) is the pixel accepted (4-i)*W + (4-j) accepts before the newest; zero before reset history
    function automatic logic signed [7:0] exp_tap(input int k);
        int idx;
        idx = total - 1 - (4 - k / 5) * W - (4 - k % 5);
        return idx >= 0 ? stream[idx] : 8'sd0;
    endfunction

    task automatic make_img(input bit rnd);
        for (int p = 0; p < N; p++) img[p] = rnd ? 8'($urandom) : 8'(p % 128);
    endtask

    task automatic drive_frame(input int gap_pct, input int abort_at, input bit noise);
        int acc, phase, cyc, bad;
        bit win_last, pv;
        acc = 0; phase = 0; cyc = 0; win_last = 0;
        strobes = 0; first_acc = 0; done_cnt = 0; done_acc = 0;
        if (noise) begin
            pixel_valid = 1'b1;
            pixel_in = 8'sd99;
            repeat (3) begin
                @(posedge clk); #1;
                bad = -1;
                for (int k = 0; k < 25; k++) if (bad < 0 && taps[k] !== exp_tap(k)) bad = k;
                n_checks++;
                if (pixel_ready !== 1'b0 || busy !== 1'b0 || valid_out_buf !== 1'b0 || bad >= 0) begin
                    n_fail++;
                    $display("FAIL idle_ignore: ready=%0b busy=%0b strobe=%0b tap_err=%0d want ready=0 busy=0 strobe=0 tap_err=-1",
                             pixel_ready, busy, valid_out_buf, bad);
                end
            end
        end
        start = 1'b1;
        pixel_valid = noise;
        @(posedge clk); #1;
        start = 1'b0;
        pixel_valid = 1'b0;
        while (phase < 2) begin
            n_checks++;
            if (pixel_ready !== (phase == 0)) begin
                n_fail++; $display("FAIL ready: got %0b want %0b at accept %0d", pixel_ready, phase == 0, acc);
            end
            n_checks++;
            if (busy !== 1'b1) begin
                n_fail++; $display("FAIL busy: got %0b want 1 at accept %0d", busy, acc);
            end
            n_checks++;
            if (frame_done !== (phase == 1)) begin
                n_fail++; $display("FAIL frame_done: got %0b want %0b at accept %0d", frame_done, phase == 1, acc);
            end
            n_checks++;
            if (valid_out_buf !== win_last) begin
                n_fail++; $display("FAIL strobe: got %0b want %0b at accept %0d", valid_out_buf, win_last, acc);
            end
            bad = -1;
            for (int k = 0; k < 25; k++) if (bad < 0 && taps[k] !== exp_tap(k)) bad = k;
            n_checks++;
            if (bad >= 0) begin
                n_fail++;
                $display("FAIL taps: data_out_%0d got %0d want %0d at accept %0d", bad, taps[bad], exp_tap(bad), acc);
            end
            if (valid_out_buf === 1'b1) begin
                strobes++;
                if (first_acc == 0) begin first_acc = acc; first_win = taps; end
                if (acc == 5 * W + 5) wrap_win = taps;
                last_win = taps;
            end
            if (frame_done === 1'b1) begin done_cnt++; done_acc = acc; end
            win_last = 0;
            start = 1'b0;
            if (phase == 1) begin
                phase = 2;
                pixel_valid = noise;
            end else begin
                if (abort_at > 0 && acc == abort_at) begin
                    rst_n = 1'b0;
                    #1;
                    bad = -1;
                    for (int k = 0; k < 25; k++) if (bad < 0 && taps[k] !== 8'sd0) bad = k;
                    n_checks++;
                    if (pixel_ready !== 1'b0 || valid_out_buf !== 1'b0 || frame_done !== 1'b0 || busy !== 1'b0 || bad >= 0) begin
                        n_fail++;
                        $display("FAIL abort_zero: ready=%0b strobe=%0b done=%0b busy=%0b tap_err=%0d want all 0 tap_err=-1",
                                 pixel_ready, valid_out_buf, frame_done, busy, bad);
                    end
                    total = 0;
                    pixel_valid = 1'b0;
                    repeat (2) @(posedge clk);
                    #1 rst_n = 1'b1;
                    @(posedge clk); #1;
                    return;
                end
                pv = $urandom_range(99) >= gap_pct;
                pixel_valid = pv;
                pixel_in = pv ? img[acc] : 8'($urandom);
                start = noise && ($urandom_range(3) == 0);
                if (pv) begin
                    stream[total] = img[acc];
                    total++;
                    win_last = (acc / W >= 4) && (acc % W >= 4);
                    acc++;
                    if (acc == N) phase = 1;
                end
            end
            @(posedge clk); #1;
            cyc++;
            if (cyc > 8000) begin
                n_checks++; n_fail++;
                $display("FAIL timeout: frame stuck at accept %0d, want %0d", acc, N);
                break;
            end
        end
        pixel_valid = 1'b0;
        start = 1'b0;
        bad = -1;
        for (int k = 0; k < 25; k++) if (bad < 0 && taps[k] !== exp_tap(k)) bad = k;
        n_checks++;
        if (busy !== 1'b0 || pixel_ready !== 1'b0 || valid_out_buf !== 1'b0 || frame_done !== 1'b0 || bad >= 0) begin
            n_fail++;
            $display("FAIL idle_after: busy=%0b ready=%0b strobe=%0b done=%0b tap_err=%0d want all 0 tap_err=-1",
                     busy, pixel_ready, valid_out_buf, frame_done, bad);
        end
    endtask

    task automatic test_reset;
        int bad;
        #1;
        bad = -1;
        for (int k = 0; k < 25; k++) if (bad < 0 && taps[k] !== 8'sd0) bad = k;
        n_checks++;
        if (pixel_ready !== 1'b0 || valid_out_buf !== 1'b0 || frame_done !== 1'b0 || busy !== 1'b0 || bad >= 0) begin
            n_fail++;
            $display("FAIL reset: ready=%0b strobe=%0b done=%0b busy=%0b tap_err=%0d want all 0 tap_err=-1",
                     pixel_ready, valid_out_buf, frame_done, busy, bad);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b0 || pixel_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_idle: busy=%0b ready=%0b want 0 0", busy, pixel_ready);
        end
    endtask

    task automatic test_ramp_frame;
        int bad;
        make_img(0);
        drive_frame(0, 0, 0);
        n_checks++;
        if (strobes !== 576) begin n_fail++; $display("FAIL ramp_strobes: got %0d want 576", strobes); end
        n_checks++;
        if (first_acc !== 117) begin n_fail++; $display("FAIL ramp_first: got accept %0d want 117", first_acc); end
        n_checks++;
        if (first_win[0] !== 8'sd0 || first_win[4] !== 8'sd4 || first_win[20] !== 8'sd112 || first_win[24] !== 8'sd116) begin
            n_fail++;
            $display("FAIL ramp_first_corners: got %0d %0d %0d %0d want 0 4 112 116",
                     first_win[0], first_win[4], first_win[20], first_win[24]);
        end
        bad = -1;
        for (int k = 0; k < 25; k++) if (bad < 0 && first_win[k] !== img[(k / 5) * W + k % 5]) bad = k;
        n_checks++;
        if (bad >= 0) begin n_fail++; $display("FAIL ramp_first_window: tap %0d got %0d want %0d", bad, first_win[bad], img[(bad / 5) * W + bad % 5]); end
        bad = -1;
        for (int k = 0; k < 25; k++) if (bad < 0 && last_win[k] !== img[(23 + k / 5) * W + 23 + k % 5]) bad = k;
        n_checks++;
        if (bad >= 0) begin n_fail++; $display("FAIL ramp_last_window: tap %0d got %0d want %0d", bad, last_win[bad], img[(23 + bad / 5) * W + 23 + bad % 5]); end
        n_checks++;
        if (last_win[24] !== 8'sd15) begin n_fail++; $display("FAIL ramp_last_tap24: got %0d want 15", last_win[24]); end
        bad = -1;
        for (int k = 0; k < 25; k++) if (bad < 0 && wrap_win[k] !== img[(1 + k / 5) * W + k % 5]) bad = k;
        n_checks++;
        if (bad >= 0) begin n_fail++; $display("FAIL row_wrap_window: tap %0d got %0d want %0d", bad, wrap_win[bad], img[(1 + bad / 5) * W + bad % 5]); end
        n_checks++;
        if (done_cnt !== 1 || done_acc !== N) begin
            n_fail++; $display("FAIL ramp_done: got count %0d at accept %0d want 1 at %0d", done_cnt, done_acc, N);
        end
    endtask

    task automatic test_gaps;
        make_img(0);
        drive_frame(30, 0, 0);
        n_checks++;
        if (strobes !== 576 || first_acc !== 117 || done_cnt !== 1) begin
            n_fail++; $display("FAIL gaps_stats: strobes %0d first %0d done %0d want 576 117 1", strobes, first_acc, done_cnt);
        end
    endtask

    task automatic test_random_image;
        make_img(1);
        drive_frame(20, 0, 0);
        n_checks++;
        if (strobes !== 576 || done_cnt !== 1) begin
            n_fail++; $display("FAIL random_stats: strobes %0d done %0d want 576 1", strobes, done_cnt);
        end
    endtask

    task automatic test_abort;
        make_img(0);
        drive_frame(0, 300, 0);
        n_checks++;
        if (done_cnt !== 0) begin n_fail++; $display("FAIL abort_done: got %0d want 0", done_cnt); end
        test_ramp_frame();
    endtask

    task automatic test_noise;
        make_img(0);
        drive_frame(0, 0, 1);
        n_checks++;
        if (strobes !== 576 || first_acc !== 117 || done_cnt !== 1 || done_acc !== N) begin
            n_fail++;
            $display("FAIL noise_stats: strobes %0d first %0d done %0d at %0d want 576 117 1 at %0d",
                     strobes, first_acc, done_cnt, done_acc, N);
        end
    endtask

    initial begin
        test_reset();
        test_ramp_frame();
        test_gaps();
        test_random_image();
        test_abort();
        test_noise();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
